// File: rtl/spr_pkg.sv
// Shared definitions for the single-port synchronous block RAM:
// read-during-write mode encodings and the byte-lane merge helper.
package spr_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } spr_wmode_e;

  // One byte lane of a byte-enable write: new data where enabled, old otherwise.
  function automatic logic [7:0] spr_byte_merge(input logic [7:0] old_b,
                                                input logic [7:0] new_b,
                                                input logic       sel);
    return sel ? new_b : old_b;
  endfunction

endpackage

// File: rtl/spr_sync_bram_if.sv
// Port bundle for spr_sync_bram: the requester drives the access, the RAM returns data.
interface spr_sync_bram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                    en;
  logic [DATA_WIDTH/8-1:0] we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    dout_valid;

  modport master (output en, we, addr, din, input dout, dout_valid);
  modport slave  (input en, we, addr, din, output dout, dout_valid);
endinterface

// File: rtl/spr_out_stage.sv
// Read latch, valid pipeline and optional output register; rst loads SRVAL and
// clears valid. Collapses to the latch alone when OUT_REG=0.
module spr_out_stage
  import spr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid
);

  logic [DATA_WIDTH-1:0] r_lat_p1;
  logic                  r_vld_p1;

  // Stage 1: read latch, captures only on a reported read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_p1 <= SRVAL;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= i_rd;
      if (i_rd) r_lat_p1 <= i_rd_data;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r_dout_p2;
    logic                  r_vld_p2;

    // Stage 2: output register advances only behind a valid stage-1 word
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dout_p2 <= SRVAL;
        r_vld_p2  <= 1'b0;
      end else begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) r_dout_p2 <= r_lat_p1;
      end
    end

    assign o_dout       = r_dout_p2;
    assign o_dout_valid = r_vld_p2;
  end else begin : g_pass
    assign o_dout       = r_lat_p1;
    assign o_dout_valid = r_vld_p1;
  end

endmodule

// File: rtl/spr_sync_bram.sv
// Single-port synchronous RAM with byte write enables, selectable
// read-during-write behaviour and an optional output pipeline register.
module spr_sync_bram
  import spr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    WRITE_MODE = 0,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
  input logic             clk,
  input logic             rst,
  spr_sync_bram_if.slave  bus
);

  localparam int                  NB       = DATA_WIDTH / 8;
  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam spr_wmode_e          LP_MODE  = spr_wmode_e'(2'(WRITE_MODE));

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("spr_sync_bram: DATA_WIDTH must be a multiple of 8");
  end
  if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_chk_aw
    $error("spr_sync_bram: ADDR_WIDTH too narrow for DEPTH");
  end
  if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_chk_wm
    $error("spr_sync_bram: WRITE_MODE must be 0, 1 or 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_in_range;
  logic                  w_any_we;
  logic                  w_rd;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_dout_valid;

  // Out-of-range addresses read as zero and never reach the array.
  always_comb begin
    w_in_range = ({1'b0, bus.addr} < LP_DEPTH);
    w_any_we   = |bus.we;
    w_idx      = bus.addr[IDX_W-1:0];
    w_old      = w_in_range ? r_mem[w_idx] : '0;
    w_merged   = '0;
    for (int i = 0; i < NB; i++) begin
      w_merged[8*i +: 8] = spr_byte_merge(w_old[8*i +: 8], bus.din[8*i +: 8], bus.we[i]);
    end
    w_rd      = bus.en && !(LP_MODE == NO_CHANGE && w_any_we);
    w_rd_data = (LP_MODE == WRITE_FIRST && w_in_range) ? w_merged : w_old;
  end

  // Array write: deliberately independent of rst so contents survive reset
  always_ff @(posedge clk) begin
    if (bus.en && w_in_range && w_any_we) r_mem[w_idx] <= w_merged;
  end

  spr_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG),
    .SRVAL      (SRVAL)
  ) u_out_stage (
    .clk          (clk),
    .rst          (rst),
    .i_rd         (w_rd),
    .i_rd_data    (w_rd_data),
    .o_dout       (w_dout),
    .o_dout_valid (w_dout_valid)
  );

  assign bus.dout       = w_dout;
  assign bus.dout_valid = w_dout_valid;

endmodule

// File: tb/tb_spr_sync_bram.sv
// Directed bench for spr_sync_bram: several configurations side by side,
// each driven through its own interface with hand-computed expectations.
module tb_spr_sync_bram;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spr_sync_bram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) ifa ();
  spr_sync_bram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) ifb ();
  spr_sync_bram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) ifc ();
  spr_sync_bram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) ifd ();
  spr_sync_bram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) ife ();

  spr_sync_bram #(.DATA_WIDTH(16), .DEPTH(256), .ADDR_WIDTH(8), .WRITE_MODE(0),
                  .OUT_REG(0), .SRVAL(16'hBEEF))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  spr_sync_bram #(.DATA_WIDTH(16), .DEPTH(256), .ADDR_WIDTH(8), .WRITE_MODE(0),
                  .OUT_REG(1), .SRVAL(16'hBEEF))
    u_b (.clk(clk), .rst(rst_b), .bus(ifb));
  spr_sync_bram #(.DATA_WIDTH(8), .DEPTH(200), .ADDR_WIDTH(8), .WRITE_MODE(0),
                  .OUT_REG(0), .SRVAL(8'h00))
    u_c (.clk(clk), .rst(rst), .bus(ifc));
  spr_sync_bram #(.DATA_WIDTH(8), .DEPTH(200), .ADDR_WIDTH(8), .WRITE_MODE(1),
                  .OUT_REG(0), .SRVAL(8'h00))
    u_d (.clk(clk), .rst(rst), .bus(ifd));
  spr_sync_bram #(.DATA_WIDTH(8), .DEPTH(200), .ADDR_WIDTH(8), .WRITE_MODE(2),
                  .OUT_REG(0), .SRVAL(8'h00))
    u_e (.clk(clk), .rst(rst), .bus(ife));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive16(input logic en, input logic [1:0] we, input logic [7:0] addr,
                         input logic [15:0] din);
    ifa.en = en; ifa.we = we; ifa.addr = addr; ifa.din = din;
    ifb.en = en; ifb.we = we; ifb.addr = addr; ifb.din = din;
  endtask

  task automatic drive8(input logic en, input logic we, input logic [7:0] addr,
                        input logic [7:0] din);
    ifc.en = en; ifc.we = we; ifc.addr = addr; ifc.din = din;
    ifd.en = en; ifd.we = we; ifd.addr = addr; ifd.din = din;
    ife.en = en; ife.we = we; ife.addr = addr; ife.din = din;
  endtask

  initial begin
    rst   = 1'b1;
    rst_b = 1'b1;
    drive16(1'b0, 2'b00, 8'd0, 16'h0000);
    drive8(1'b0, 1'b0, 8'd0, 8'h00);

    // Reset values
    tick(); tick();
    chk("a_rst_dout", ifa.dout, 16'hBEEF);
    chk("a_rst_vld",  16'(ifa.dout_valid), 16'h0);
    chk("b_rst_dout", ifb.dout, 16'hBEEF);
    chk("b_rst_vld",  16'(ifb.dout_valid), 16'h0);
    chk("c_rst_dout", 16'(ifc.dout), 16'h0000);
    chk("c_rst_vld",  16'(ifc.dout_valid), 16'h0);
    rst   = 1'b0;
    rst_b = 1'b0;

    // Byte enables, both output-register settings
    drive16(1'b1, 2'b11, 8'd5, 16'h1234); tick();
    drive16(1'b1, 2'b10, 8'd5, 16'hAB00); tick();
    chk("a_rf_old_dout", ifa.dout, 16'h1234);
    chk("a_rf_old_vld",  16'(ifa.dout_valid), 16'h1);
    drive16(1'b1, 2'b00, 8'd5, 16'h0000); tick();
    chk("a_be_dout", ifa.dout, 16'hAB34);
    chk("a_be_vld",  16'(ifa.dout_valid), 16'h1);
    chk("b_lat2_dout", ifb.dout, 16'h1234);
    chk("b_lat2_vld",  16'(ifb.dout_valid), 16'h1);
    drive16(1'b0, 2'b00, 8'd0, 16'h0000); tick();
    chk("a_hold_dout", ifa.dout, 16'hAB34);
    chk("a_pulse_vld", 16'(ifa.dout_valid), 16'h0);
    chk("b_be_dout", ifb.dout, 16'hAB34);
    chk("b_be_vld",  16'(ifb.dout_valid), 16'h1);
    tick();
    chk("b_hold_dout", ifb.dout, 16'hAB34);
    chk("b_pulse_vld", 16'(ifb.dout_valid), 16'h0);

    // Mid-operation reset on the registered-output instance
    for (int i = 1; i <= 4; i++) begin
      drive16(1'b1, 2'b11, 8'(i), 16'(i) * 16'h1111); tick();
    end
    drive16(1'b0, 2'b00, 8'd0, 16'h0000); tick(); tick();
    drive16(1'b1, 2'b00, 8'd1, 16'h0000); tick();
    drive16(1'b0, 2'b00, 8'd0, 16'h0000);
    rst_b = 1'b1; tick();
    chk("b_midrst_dout", ifb.dout, 16'hBEEF);
    chk("b_midrst_vld",  16'(ifb.dout_valid), 16'h0);
    rst_b = 1'b0; tick();
    chk("b_lost_dout", ifb.dout, 16'hBEEF);
    chk("b_lost_vld",  16'(ifb.dout_valid), 16'h0);
    for (int i = 1; i <= 4; i++) begin
      drive16(1'b1, 2'b00, 8'(i), 16'h0000); tick();
      if (i == 1) begin
        chk("b_stream_lat_vld", 16'(ifb.dout_valid), 16'h0);
      end else begin
        chk("b_stream_dout", ifb.dout, 16'(i - 1) * 16'h1111);
        chk("b_stream_vld",  16'(ifb.dout_valid), 16'h1);
      end
    end
    drive16(1'b0, 2'b00, 8'd0, 16'h0000); tick();
    chk("b_stream4_dout", ifb.dout, 16'h4444);
    chk("b_stream4_vld",  16'(ifb.dout_valid), 16'h1);
    tick();
    chk("b_stream_end_vld", 16'(ifb.dout_valid), 16'h0);

    // Read-during-write in the three modes
    drive8(1'b1, 1'b1, 8'd3, 8'h11); tick();
    drive8(1'b1, 1'b1, 8'd4, 8'h77); tick();
    drive8(1'b1, 1'b0, 8'd4, 8'h00); tick();
    chk("c_pre_dout", 16'(ifc.dout), 16'h0077);
    chk("d_pre_dout", 16'(ifd.dout), 16'h0077);
    chk("e_pre_dout", 16'(ife.dout), 16'h0077);
    chk("e_pre_vld",  16'(ife.dout_valid), 16'h1);
    drive8(1'b0, 1'b0, 8'd0, 8'h00); tick();
    drive8(1'b1, 1'b1, 8'd3, 8'h22); tick();
    chk("rdw_rf_dout", 16'(ifc.dout), 16'h0011);
    chk("rdw_rf_vld",  16'(ifc.dout_valid), 16'h1);
    chk("rdw_wf_dout", 16'(ifd.dout), 16'h0022);
    chk("rdw_wf_vld",  16'(ifd.dout_valid), 16'h1);
    chk("rdw_nc_dout", 16'(ife.dout), 16'h0077);
    chk("rdw_nc_vld",  16'(ife.dout_valid), 16'h0);
    drive8(1'b1, 1'b0, 8'd3, 8'h00); tick();
    chk("rdw_rf_after", 16'(ifc.dout), 16'h0022);
    chk("rdw_wf_after", 16'(ifd.dout), 16'h0022);
    chk("rdw_nc_after", 16'(ife.dout), 16'h0022);
    chk("rdw_nc_after_vld", 16'(ife.dout_valid), 16'h1);

    // en low blocks writes and reads
    drive8(1'b1, 1'b1, 8'd7, 8'h3C); tick();
    drive8(1'b1, 1'b0, 8'd3, 8'h00); tick();
    chk("c_prior_dout", 16'(ifc.dout), 16'h0022);
    drive8(1'b0, 1'b1, 8'd7, 8'hFF); tick();
    chk("c_enlow_dout", 16'(ifc.dout), 16'h0022);
    chk("c_enlow_vld",  16'(ifc.dout_valid), 16'h0);
    chk("e_enlow_vld",  16'(ife.dout_valid), 16'h0);
    drive8(1'b1, 1'b0, 8'd7, 8'h00); tick();
    chk("c_enlow_mem", 16'(ifc.dout), 16'h003C);
    chk("c_enlow_mem_vld", 16'(ifc.dout_valid), 16'h1);
    chk("d_enlow_mem", 16'(ifd.dout), 16'h003C);

    // Out-of-range addresses with DEPTH=200
    drive8(1'b1, 1'b1, 8'd10, 8'hA5); tick();
    drive8(1'b1, 1'b1, 8'd210, 8'h55); tick();
    chk("c_oor_wr_dout", 16'(ifc.dout), 16'h0000);
    chk("c_oor_wr_vld",  16'(ifc.dout_valid), 16'h1);
    chk("d_oor_wr_dout", 16'(ifd.dout), 16'h0000);
    drive8(1'b1, 1'b0, 8'd210, 8'h00); tick();
    chk("c_oor_rd_dout", 16'(ifc.dout), 16'h0000);
    chk("c_oor_rd_vld",  16'(ifc.dout_valid), 16'h1);
    drive8(1'b1, 1'b0, 8'd10, 8'h00); tick();
    chk("c_alias_dout", 16'(ifc.dout), 16'h00A5);
    chk("d_alias_dout", 16'(ifd.dout), 16'h00A5);
    chk("e_alias_dout", 16'(ife.dout), 16'h00A5);
    drive8(1'b0, 1'b0, 8'd0, 8'h00); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
